// File: rtl/risc_eu_param.sv
// Parametrised RISC16-family execution unit: PC, IR, register file, ALU and latched flags.
// Optional build macro EU_REG0_ZERO_EN: R0 reads as zero and ignores writes.
module risc_eu_param #(
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 16,
    parameter int unsigned RA_W  = 3,
    parameter int unsigned OFF_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          s_sel,
    input  logic          adr_sel,
    input  logic          pc_sel,
    input  logic          pc_ld,
    input  logic          pc_inc,
    input  logic          ir_ld,
    input  logic          flag_ld,
    input  logic [DW-1:0] din,
    output logic [AW-1:0] address,
    output logic [DW-1:0] dout,
    output logic          c,
    output logic          n,
    output logic          z,
    output logic          alu_c,
    output logic          alu_n,
    output logic          alu_z,
    output logic [AW-1:0] pc_q,
    output logic [DW-1:0] ir_q
);

    localparam int unsigned NREG = 2 ** RA_W;

    typedef enum logic [3:0] {
        OP_R    = 4'h0,
        OP_S    = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_INC  = 4'h4,
        OP_DEC  = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_XOR  = 4'h8,
        OP_NOT  = 4'h9,
        OP_SHL  = 4'hA,
        OP_SHR  = 4'hB,
        OP_SAR  = 4'hC,
        OP_NEG  = 4'hD,
        OP_ZERO = 4'hE,
        OP_ONES = 4'hF
    } alu_op_e;

    logic [AW-1:0] pc_d;
    logic [DW-1:0] ir_d;
    logic [2:0]    flags_q, flags_d;
    logic [DW-1:0] rf_q [NREG];
    logic [DW-1:0] rf_d [NREG];

    alu_op_e       op;
    logic [RA_W-1:0] w_adr, r_adr, s_adr;
    logic [DW-1:0] r_val, s_val, alu_res;
    logic [DW:0]   alu_wide;
    logic          alu_cy;
    logic [AW-1:0] alu_aw, r_aw, off_ext;

    assign op    = alu_op_e'(ir_q[DW-1:DW-4]);
    assign w_adr = ir_q[3*RA_W-1:2*RA_W];
    assign r_adr = ir_q[2*RA_W-1:RA_W];
    assign s_adr = ir_q[RA_W-1:0];

    always_comb begin
        r_val = rf_q[r_adr];
        s_val = s_sel ? din : rf_q[s_adr];
`ifdef EU_REG0_ZERO_EN
        if (r_adr == '0) r_val = '0;
        if (!s_sel && (s_adr == '0)) s_val = '0;
`endif
    end

    // Arithmetic ops run one bit wider; the extra bit is carry for add, borrow for subtract.
    always_comb begin
        alu_res  = '0;
        alu_wide = '0;
        alu_cy   = 1'b0;
        case (op)
            OP_R:    alu_res = r_val;
            OP_S:    alu_res = s_val;
            OP_ADD:  begin alu_wide = {1'b0, r_val} + {1'b0, s_val};   {alu_cy, alu_res} = alu_wide; end
            OP_SUB:  begin alu_wide = {1'b0, r_val} - {1'b0, s_val};   {alu_cy, alu_res} = alu_wide; end
            OP_INC:  begin alu_wide = {1'b0, r_val} + (DW+1)'(1);      {alu_cy, alu_res} = alu_wide; end
            OP_DEC:  begin alu_wide = {1'b0, r_val} - (DW+1)'(1);      {alu_cy, alu_res} = alu_wide; end
            OP_AND:  alu_res = r_val & s_val;
            OP_OR:   alu_res = r_val | s_val;
            OP_XOR:  alu_res = r_val ^ s_val;
            OP_NOT:  alu_res = ~r_val;
            OP_SHL:  begin alu_res = {r_val[DW-2:0], 1'b0};        alu_cy = r_val[DW-1]; end
            OP_SHR:  begin alu_res = {1'b0, r_val[DW-1:1]};        alu_cy = r_val[0];    end
            OP_SAR:  begin alu_res = {r_val[DW-1], r_val[DW-1:1]}; alu_cy = r_val[0];    end
            OP_NEG:  begin alu_wide = (DW+1)'(0) - {1'b0, r_val};  {alu_cy, alu_res} = alu_wide; end
            OP_ZERO: alu_res = '0;
            OP_ONES: alu_res = '1;
            default: alu_res = '0;
        endcase
    end

    assign dout  = alu_res;
    assign alu_c = alu_cy;
    assign alu_n = alu_res[DW-1];
    assign alu_z = (alu_res == '0);

    // Data-width values feeding the PC or the address bus are zero-extended or truncated.
    if (AW > DW) begin : g_zext
        assign alu_aw = {{(AW-DW){1'b0}}, alu_res};
        assign r_aw   = {{(AW-DW){1'b0}}, r_val};
    end else begin : g_trunc
        assign alu_aw = alu_res[AW-1:0];
        assign r_aw   = r_val[AW-1:0];
    end

    assign off_ext = AW'($signed(ir_q[OFF_W-1:0]));
    assign address = adr_sel ? r_aw : pc_q;

    always_comb begin
        pc_d = pc_q;
        if (pc_inc)
            pc_d = pc_q + AW'(1);
        else if (pc_ld)
            pc_d = pc_sel ? alu_aw : (pc_q + off_ext);

        ir_d    = ir_ld ? din : ir_q;
        flags_d = flag_ld ? {alu_c, alu_n, alu_z} : flags_q;

        for (int unsigned i = 0; i < NREG; i++) rf_d[i] = rf_q[i];
        if (we) rf_d[w_adr] = alu_res;
`ifdef EU_REG0_ZERO_EN
        rf_d[0] = '0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            ir_q    <= '0;
            flags_q <= '0;
            for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
            rf_q    <= rf_d;
        end
    end

    assign c = flags_q[2];
    assign n = flags_q[1];
    assign z = flags_q[0];

endmodule
